// File: rtl/dsm_ctrl_pkg.sv
// dsm_ctrl_pkg: shared widths, state codes and modulator-reset length for the DSM sequencer
package dsm_ctrl_pkg;
  localparam int OSR_W_DEF = 16;
  localparam int SET_W_DEF = 8;
  localparam int MRST_LEN = 2;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_MRST   = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_INTEG  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
endpackage

// File: rtl/dsm_sinc1_acc.sv
// dsm_sinc1_acc: signed +/-1 integrator for the modulator bitstream
module dsm_sinc1_acc #(
  parameter int RES_W = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    bit_i,
  output logic signed [RES_W-1:0] acc_o,
  output logic signed [RES_W-1:0] sum_o
);
  logic signed [RES_W-1:0] acc_q;
  assign acc_o = acc_q;
  assign sum_o = acc_q + (bit_i ? {{(RES_W-1){1'b0}}, 1'b1} : {RES_W{1'b1}});
  // Clear wins over accumulate so a new window never inherits the old sum
  always_ff @(posedge clk)
    if (rst || clr_i) acc_q <= '0;
    else if (en_i) acc_q <= sum_o;
endmodule

// File: rtl/dsm_conv_ctrl.sv
// dsm_conv_ctrl: reset/settle/integrate sequencer with start/busy/done handshake
module dsm_conv_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int OSR_W = OSR_W_DEF,
  parameter int SET_W = SET_W_DEF,
  parameter int RES_W = OSR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cont,
  input  logic [OSR_W-1:0]        osr,
  input  logic [SET_W-1:0]        settle,
  input  logic                    dsm_bit,
  output logic                    dsm_rstx,
  output logic                    busy,
  output logic                    done,
  output logic signed [RES_W-1:0] result
);
  localparam int CNT_W = OSR_W > SET_W ? OSR_W : SET_W;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OSR_W-1:0] osr_q, osr_d;
  logic [SET_W-1:0] set_q, set_d;
  logic signed [RES_W-1:0] result_q, res_d, acc, sum;
  logic clr;
  dsm_sinc1_acc #(.RES_W(RES_W)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .en_i  (state_q == ST_INTEG),
    .bit_i (dsm_bit),
    .acc_o (acc),
    .sum_o (sum)
  );
  assign dsm_rstx = state_q == ST_SETTLE || state_q == ST_INTEG || state_q == ST_DONE;
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  assign result = result_q;
  // Next state: the counter holds remaining cycles minus one of the current phase
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    osr_d = osr_q;
    set_d = set_q;
    res_d = result_q;
    clr = 1'b0;
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
    else case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_MRST;
        cnt_d = CNT_W'(MRST_LEN - 1);
        osr_d = osr;
        set_d = settle;
        clr = 1'b1;
      end
      ST_MRST, ST_SETTLE: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else if (state_q == ST_MRST && set_q != '0) begin
        state_d = ST_SETTLE;
        cnt_d = CNT_W'(set_q) - CNT_W'(1);
      end else begin
        state_d = osr_q != '0 ? ST_INTEG : ST_DONE;
        cnt_d = CNT_W'(osr_q) - CNT_W'(1);
        res_d = osr_q != '0 ? result_q : acc;
      end
      ST_INTEG: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else begin
        state_d = ST_DONE;
        res_d = sum;
      end
      ST_DONE: if (cont) begin
        osr_d = osr;
        clr = 1'b1;
        state_d = osr != '0 ? ST_INTEG : ST_DONE;
        cnt_d = CNT_W'(osr) - CNT_W'(1);
        res_d = osr != '0 ? result_q : '0;
      end else state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  // State, counters, latched config and result register
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      osr_q <= '0;
      set_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      osr_q <= osr_d;
      set_q <= set_d;
      result_q <= res_d;
    end
endmodule
